// File: rtl/ssio_ddr_in_delay_train.sv
//==============================================================================
// Module      : ssio_ddr_in_delay_train
// Description : Sweeps input-delay taps against a known DDR pattern and
//               centres the delay in the widest passing window.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module ssio_ddr_in_delay_train #(
    parameter int               WIDTH         = 1,
    parameter int               TAP_BITS      = 5,
    parameter logic [WIDTH-1:0] PAT_Q1        = '1,
    parameter logic [WIDTH-1:0] PAT_Q2        = '0,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               CHECK_CYCLES  = 64,
    parameter int               MIN_EYE       = 3,
    parameter int               TAP_DEFAULT   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    q1,
    input  logic [WIDTH-1:0]    q2,
    output logic                delay_ld,
    output logic [TAP_BITS-1:0] delay_tap,
    output logic                busy,
    output logic                locked,
    output logic                error,
    output logic [TAP_BITS-1:0] eye_start,
    output logic [TAP_BITS:0]   eye_width
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    c_settle_init = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_check_init  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_one     = CNT_W'(1);
    localparam logic [TAP_BITS:0]   c_last_tap    = {1'b0, {TAP_BITS{1'b1}}};
    localparam logic [TAP_BITS:0]   c_len_one     = (TAP_BITS+1)'(1);
    localparam logic [TAP_BITS:0]   c_min_eye     = (TAP_BITS+1)'(MIN_EYE);
    localparam logic [TAP_BITS-1:0] c_tap_default = TAP_BITS'(TAP_DEFAULT);
    localparam logic [TAP_BITS-1:0] c_tap_one     = TAP_BITS'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_APPLY  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [TAP_BITS:0]   r_tap;
    logic                r_pass;
    logic                r_run_active;
    logic [TAP_BITS-1:0] r_run_start;
    logic [TAP_BITS:0]   r_run_len;

    logic                w_match;
    logic                w_last;
    logic [TAP_BITS-1:0] w_ext_start;
    logic [TAP_BITS:0]   w_ext_len;
    logic                w_cand_valid;
    logic [TAP_BITS-1:0] w_cand_start;
    logic [TAP_BITS:0]   w_cand_len;
    logic                w_take;
    logic [TAP_BITS:0]   w_center;
    logic                w_eye_ok;

    assign w_match     = (q1 == PAT_Q1) && (q2 == PAT_Q2);
    assign w_last      = (r_tap == c_last_tap);
    assign w_ext_start = r_run_active ? r_run_start : r_tap[TAP_BITS-1:0];
    assign w_ext_len   = r_run_active ? (r_run_len + c_len_one) : c_len_one;

    // A passing tap only closes its run at the end of the sweep; a failing
    // tap closes whatever run was open before it.
    always_comb begin
        w_cand_valid = r_run_active;
        w_cand_start = r_run_start;
        w_cand_len   = r_run_len;
        if (r_pass) begin
            w_cand_valid = w_last;
            w_cand_start = w_ext_start;
            w_cand_len   = w_ext_len;
        end
    end

    assign w_take   = w_cand_valid && (w_cand_len > eye_width);
    assign w_center = {1'b0, eye_start} + {1'b0, eye_width[TAP_BITS:1]};
    assign w_eye_ok = (eye_width >= c_min_eye);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tap        <= '0;
            r_pass       <= 1'b0;
            r_run_active <= 1'b0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            delay_ld     <= 1'b0;
            delay_tap    <= '0;
            busy         <= 1'b0;
            locked       <= 1'b0;
            error        <= 1'b0;
            eye_start    <= '0;
            eye_width    <= '0;
        end else begin
            delay_ld <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        locked       <= 1'b0;
                        error        <= 1'b0;
                        eye_start    <= '0;
                        eye_width    <= '0;
                        r_run_active <= 1'b0;
                        r_run_start  <= '0;
                        r_run_len    <= '0;
                        r_tap        <= '0;
                        busy         <= 1'b1;
                        delay_ld     <= 1'b1;
                        delay_tap    <= '0;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= c_settle_init;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= c_check_init;
                        r_pass  <= 1'b1;
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_CHECK: begin
                    r_pass <= r_pass & w_match;
                    if (r_cnt == '0) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_EVAL: begin
                    if (w_take) begin
                        eye_start <= w_cand_start;
                        eye_width <= w_cand_len;
                    end
                    if (r_pass && !w_last) begin
                        r_run_active <= 1'b1;
                        r_run_start  <= w_ext_start;
                        r_run_len    <= w_ext_len;
                    end else begin
                        r_run_active <= 1'b0;
                        r_run_len    <= '0;
                    end
                    if (w_last) begin
                        r_state <= S_APPLY;
                    end else begin
                        r_tap     <= r_tap + c_len_one;
                        delay_tap <= r_tap[TAP_BITS-1:0] + c_tap_one;
                        delay_ld  <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_APPLY: begin
                    delay_ld <= 1'b1;
                    busy     <= 1'b0;
                    if (w_eye_ok) begin
                        // Saturate rather than wrap should the centre ever overflow.
                        delay_tap <= w_center[TAP_BITS] ? {TAP_BITS{1'b1}} : w_center[TAP_BITS-1:0];
                        locked    <= 1'b1;
                    end else begin
                        delay_tap <= c_tap_default;
                        error     <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ssio_ddr_in_delay_train.sv
//==============================================================================
// Module      : tb_ssio_ddr_in_delay_train
// Description : Randomised tap-pass maps scored against a run-length model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_ssio_ddr_in_delay_train;

    localparam int WIDTH = 4;
    localparam int TAPB  = 5;
    localparam int NT    = 32;
    localparam int S     = 16;
    localparam int C     = 64;
    localparam int MINE  = 3;
    localparam int TDEF  = 6;
    localparam logic [WIDTH-1:0] P1 = 4'hA;
    localparam logic [WIDTH-1:0] P2 = 4'h5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] q1 = '0;
    logic [WIDTH-1:0] q2 = '0;
    logic             delay_ld;
    logic [TAPB-1:0]  delay_tap;
    logic             busy, locked, error;
    logic [TAPB-1:0]  eye_start;
    logic [TAPB:0]    eye_width;

    ssio_ddr_in_delay_train #(
        .WIDTH(WIDTH), .TAP_BITS(TAPB), .PAT_Q1(P1), .PAT_Q2(P2),
        .SETTLE_CYCLES(S), .CHECK_CYCLES(C), .MIN_EYE(MINE), .TAP_DEFAULT(TDEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q1(q1), .q2(q2),
        .delay_ld(delay_ld), .delay_tap(delay_tap), .busy(busy),
        .locked(locked), .error(error), .eye_start(eye_start), .eye_width(eye_width)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int wd;
        int tap;
        int lk;
        int er;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pass_map = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Widest run of consecutive passing taps, earliest wins ties.
    function automatic exp_t model(input logic [31:0] m);
        exp_t e;
        int   i, j;
        e.st = 0; e.wd = 0;
        i = 0;
        while (i < NT) begin
            if (m[i]) begin
                j = i;
                while (j < NT && m[j]) j++;
                if (j - i > e.wd) begin
                    e.wd = j - i;
                    e.st = i;
                end
                i = j;
            end else begin
                i++;
            end
        end
        e.lk  = (e.wd >= MINE) ? 1 : 0;
        e.er  = 1 - e.lk;
        e.tap = e.lk ? (e.st + e.wd / 2) : TDEF;
        e.cyc = NT * (1 + S + C + 1) + 2;
        return e;
    endfunction

    // Pattern driver: cycle n after a load is settle for n<=S, check for S<n<=S+C.
    initial begin
        int t, mode, lo, hi, sbad, flip;
        bit p, bad;
        forever begin
            @(posedge clk); #1;
            q1 = WIDTH'($urandom); q2 = WIDTH'($urandom);
            if (rst_n && delay_ld && busy) begin
                t    = int'(delay_tap);
                p    = pass_map[t];
                mode = $urandom_range(0, 3);
                sbad = (mode == 0) ? S : $urandom_range(1, S);
                case (mode)
                    0: begin lo = S + 1; hi = S + C; end
                    1: begin lo = S + 1; hi = S + 1; end
                    2: begin lo = S + C; hi = S + C; end
                    default: begin lo = $urandom_range(S + 1, S + C); hi = lo; end
                endcase
                for (int n = 1; n <= S + C; n++) begin
                    @(posedge clk); #1;
                    if (!rst_n) break;
                    bad = (n > S) ? (!p && n >= lo && n <= hi) : (n == sbad);
                    q1 = P1; q2 = P2;
                    if (bad) begin
                        flip = $urandom_range(1, 15);
                        if ($urandom_range(0, 1) == 1) q1 = P1 ^ WIDTH'(flip);
                        else                           q2 = P2 ^ WIDTH'(flip);
                    end
                end
            end
        end
    end

    // Monitor: load sequence, clearing on start, and final result at busy fall.
    initial begin
        int   busy_cyc, load_idx;
        bit   prev_busy;
        exp_t e;
        busy_cyc = 0; load_idx = 0; prev_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_busy = 1'b0; busy_cyc = 0; load_idx = 0;
                continue;
            end
            if (busy) begin
                if (!prev_busy) begin
                    busy_cyc = 0; load_idx = 0;
                    chk("clear_on_start", int'({locked, error, eye_start, eye_width}), 0);
                end
                busy_cyc++;
                if (delay_ld) begin
                    chk("load_tap", int'(delay_tap), load_idx);
                    load_idx++;
                end
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sweep_cycles", busy_cyc + 1, e.cyc);
                    chk("load_count", load_idx, NT);
                    chk("final_ld", int'(delay_ld), 1);
                    chk("final_tap", int'(delay_tap), e.tap);
                    chk("locked", int'(locked), e.lk);
                    chk("error", int'(error), e.er);
                    chk("eye_start", int'(eye_start), e.st);
                    chk("eye_width", int'(eye_width), e.wd);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_sweep(input logic [31:0] m);
        pass_map = m;
        sb.push_back(model(m));
        pulse_start();
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("sweep_timeout", 1, 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] range_map(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [31:0] m;
        int          loads;
        int          bad_ld;
        repeat (3) @(negedge clk);
        chk("reset_state", int'({delay_ld, delay_tap, busy, locked, error, eye_start, eye_width}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(range_map(10, 19));
        run_sweep(range_map(3, 5) | range_map(20, 27));
        run_sweep(range_map(2, 5) | range_map(10, 13));
        run_sweep(range_map(28, 31));
        run_sweep(32'h0);
        run_sweep(range_map(7, 8));
        run_sweep(range_map(10, 14) | range_map(16, 19));
        run_sweep(32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NT; i++) m[i] = ($urandom_range(0, 3) != 0);
            run_sweep(m);
        end

        // Abort a sweep in the settle phase of tap 9; a start mid-sweep is ignored.
        pass_map = range_map(10, 19);
        pulse_start();
        loads = 0;
        for (int i = 0; i < 2000 && loads < 10; i++) begin
            @(posedge clk); #1;
            if (delay_ld && busy) begin
                loads++;
                if (loads == 6) pulse_start();
            end
        end
        chk("reached_tap9", loads, 10);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", int'({delay_ld, delay_tap, busy, locked, error, eye_start, eye_width}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad_ld = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (delay_ld || busy) bad_ld++;
        end
        chk("quiet_after_reset", bad_ld, 0);
        run_sweep(range_map(10, 19));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
